// File: rtl/cube_arb_pkg.sv
// Shared types and defaults for the cube-root unit arbiter.
package cube_arb_pkg;

  // Default geometry and watchdog limit
  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int RES_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  // Result returned when the watchdog aborts a job (sliced to RES_W at use)
  localparam logic [63:0] RES_ERR = '1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RESP      = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import cube_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int   cand_s;
  logic found_s;

  // Rotate the scan start to ptr and take the first pending request
  always_comb begin
    gnt     = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = int'(ptr) + i;
      cand_s = (cand_s >= N_REQ) ? (cand_s - N_REQ) : cand_s;
      if (!found_s && req[cand_s[IDX_W-1:0]]) begin
        found_s                  = 1'b1;
        gnt[cand_s[IDX_W-1:0]]   = 1'b1;
        idx                      = cand_s[IDX_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    valid = found_s;
  end

endmodule

// File: rtl/cube_arbiter.sv
// Round-robin front end sharing one cube-root unit between N_REQ clients,
// with a watchdog that aborts a job the unit never finishes.
module cube_arbiter
  import cube_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] x_bi,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [RES_W-1:0]        y_bo,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    cr_start_o,
  output logic [DATA_W-1:0]       cr_x_bo,
  input  logic                    cr_busy_i,
  input  logic [RES_W-1:0]        cr_y_bi
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  arb_state_e          state_r;
  logic [IDX_W-1:0]    ptr_r;
  logic [N_REQ-1:0]    gnt_r;
  logic [N_REQ-1:0]    done_r;
  logic [RES_W-1:0]    y_r;
  logic                err_r;
  logic                busy_r;
  logic                cr_start_r;
  logic [DATA_W-1:0]   x_r;
  logic [WD_W-1:0]     wdog_r;
  logic                dropped_r;

  logic [N_REQ-1:0]    win_gnt_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic                win_valid_s;
  logic [IDX_W-1:0]    nxt_ptr_s;
  logic [DATA_W-1:0]   win_x_s;
  logic                own_req_s;
  logic                deliver_s;
  logic                wdog_hit_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req_i),
    .ptr   (ptr_r),
    .gnt   (win_gnt_s),
    .idx   (win_idx_s),
    .valid (win_valid_s)
  );

  // Pointer advances past the winner, wrapping at N_REQ
  always_comb begin
    if (win_idx_s == IDX_W'(N_REQ - 1)) begin
      nxt_ptr_s = '0;
    end else begin
      nxt_ptr_s = win_idx_s + IDX_W'(1);
    end
  end

  // Select the winning client's operand slice
  always_comb begin
    win_x_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_gnt_s[k]) begin
        win_x_s = x_bi[k*DATA_W +: DATA_W];
      end else begin
        win_x_s = win_x_s;
      end
    end
  end

  // Result goes back only if the granted client kept its request the whole job
  always_comb begin
    own_req_s  = |(gnt_r & req_i);
    deliver_s  = own_req_s & ~dropped_r;
    wdog_hit_s = (wdog_r == WD_W'(TIMEOUT - 1));
  end

  // Controller FSM with registered grant, handshake and response outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      y_r        <= '0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      cr_start_r <= 1'b0;
      x_r        <= '0;
      wdog_r     <= '0;
      dropped_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wdog_r    <= '0;
          dropped_r <= 1'b0;
          done_r    <= '0;
          y_r       <= '0;
          err_r     <= 1'b0;
          if (win_valid_s) begin
            gnt_r      <= win_gnt_s;
            x_r        <= win_x_s;
            ptr_r      <= nxt_ptr_s;
            cr_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_START;
          end else begin
            busy_r     <= 1'b0;
            cr_start_r <= 1'b0;
          end
        end
        ST_START: begin
          dropped_r <= dropped_r | ~own_req_s;
          if (wdog_hit_s) begin
            cr_start_r <= 1'b0;
            done_r     <= deliver_s ? gnt_r : '0;
            y_r        <= deliver_s ? RES_ERR[RES_W-1:0] : '0;
            err_r      <= deliver_s;
            state_r    <= ST_RESP;
          end else if (cr_busy_i) begin
            cr_start_r <= 1'b0;
            wdog_r     <= wdog_r + WD_W'(1);
            state_r    <= ST_WAIT_DONE;
          end else begin
            wdog_r     <= wdog_r + WD_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          dropped_r <= dropped_r | ~own_req_s;
          if (!cr_busy_i) begin
            done_r  <= deliver_s ? gnt_r : '0;
            y_r     <= deliver_s ? cr_y_bi : '0;
            err_r   <= 1'b0;
            state_r <= ST_RESP;
          end else if (wdog_hit_s) begin
            done_r  <= deliver_s ? gnt_r : '0;
            y_r     <= deliver_s ? RES_ERR[RES_W-1:0] : '0;
            err_r   <= deliver_s;
            state_r <= ST_RESP;
          end else begin
            wdog_r  <= wdog_r + WD_W'(1);
          end
        end
        ST_RESP: begin
          done_r     <= '0;
          y_r        <= '0;
          err_r      <= 1'b0;
          gnt_r      <= '0;
          busy_r     <= 1'b0;
          cr_start_r <= 1'b0;
          wdog_r     <= '0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt_r      <= '0;
          done_r     <= '0;
          y_r        <= '0;
          err_r      <= 1'b0;
          busy_r     <= 1'b0;
          cr_start_r <= 1'b0;
          wdog_r     <= '0;
        end
      endcase
    end
  end

  assign gnt_o      = gnt_r;
  assign done_o     = done_r;
  assign y_bo       = y_r;
  assign err_o      = err_r;
  assign busy_o     = busy_r;
  assign cr_start_o = cr_start_r;
  assign cr_x_bo    = x_r;

endmodule

// File: tb/tb_cube_arbiter.sv
// Directed scoreboard bench for cube_arbiter with a behavioural cube-root unit.
module tb_cube_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int RW       = 8;
  localparam int TO       = 255;
  localparam int CUBE_LAT = 4;

  logic            clk;
  logic            rst_i;
  logic [N-1:0]    req;
  logic [N*DW-1:0] x_bus;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [RW-1:0]   y;
  logic            err;
  logic            busy;
  logic            cr_start;
  logic [DW-1:0]   cr_x;
  logic            cr_busy;
  logic [RW-1:0]   cr_y;
  logic            tie_busy;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [RW-1:0] y;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   done_cnt [N];

  cube_arbiter #(
    .N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req),
    .x_bi       (x_bus),
    .gnt_o      (gnt),
    .done_o     (done),
    .y_bo       (y),
    .err_o      (err),
    .busy_o     (busy),
    .cr_start_o (cr_start),
    .cr_x_bo    (cr_x),
    .cr_busy_i  (cr_busy),
    .cr_y_bi    (cr_y)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural cube-root unit: busy for CUBE_LAT cycles after start
  function automatic logic [RW-1:0] cbrt(input logic [DW-1:0] v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= int'(v)) r++;
    return RW'(r);
  endfunction

  logic          m_busy;
  logic [DW-1:0] m_x;
  logic [RW-1:0] m_y;
  int            m_cnt;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_busy <= 1'b0;
      m_x    <= '0;
      m_y    <= '0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (cr_start) begin
        m_busy <= 1'b1;
        m_x    <= cr_x;
        m_cnt  <= CUBE_LAT;
      end
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else begin
      m_busy <= 1'b0;
      m_y    <= cbrt(m_x);
    end
  end

  assign cr_busy = tie_busy ? 1'b0 : m_busy;
  assign cr_y    = m_y;

  // Count done pulses per client
  always @(negedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < N; k++) if (done[k]) done_cnt[k] = done_cnt[k] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] g, input logic [RW-1:0] v, input logic e);
    exp_t it;
    it.gnt = g;
    it.y   = v;
    it.err = e;
    sb_q.push_back(it);
  endtask

  task automatic set_x(input int k, input logic [DW-1:0] v);
    x_bus[k*DW +: DW] = v;
  endtask

  // Step negedges until done_o fires, then compare against the scoreboard head
  task automatic wait_done(input string tag, input int budget, output int cycles);
    exp_t e;
    bit   seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done != '0) seen = 1'b1;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_done"}, 64'(done), 64'(e.gnt));
      check({tag, "_y"},    64'(y),    64'(e.y));
      check({tag, "_err"},  64'(err),  64'(e.err));
    end
  endtask

  initial begin
    int cyc;
    int snap;
    logic [N-1:0]  acc_done;
    logic [RW-1:0] acc_y;
    logic          acc_err;

    checks   = 0;
    errors   = 0;
    for (int k = 0; k < N; k++) done_cnt[k] = 0;
    rst_i    = 1'b0;
    req      = '0;
    x_bus    = '0;
    tie_busy = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({gnt, done, y, err, busy, cr_start, cr_x}), 64'd0);
    rst_i = 1'b1;
    @(negedge clk);

    // 1 Single request
    set_x(0, 8'd27);
    req = 4'b0001;
    push_exp(4'b0001, 8'd3, 1'b0);
    @(negedge clk);
    check("t1_gnt",   64'(gnt),      64'h1);
    check("t1_start", 64'(cr_start), 64'd1);
    check("t1_x",     64'(cr_x),     64'd27);
    wait_done("t1", 40, cyc);
    req = 4'b0000;
    @(negedge clk);
    check("t1_idle", 64'({done, gnt, busy}), 64'd0);
    check("t1_once", 64'(done_cnt[0]), 64'd1);

    // 2 Sweep on client 2, one idle cycle between back-to-back jobs
    set_x(2, 8'd0);
    req = 4'b0100;
    push_exp(4'b0100, 8'd0, 1'b0);
    for (int i = 0; i <= 6; i++) begin
      wait_done("t2", 40, cyc);
      if (i < 6) begin
        set_x(2, DW'((i + 1) * (i + 1) * (i + 1)));
        push_exp(4'b0100, RW'(i + 1), 1'b0);
        @(negedge clk);
        check("t2_gap_low", 64'(busy), 64'd0);
        @(negedge clk);
        check("t2_gap_high", 64'(busy), 64'd1);
      end
    end
    req = 4'b0000;
    @(negedge clk);

    // Reset pulse so arbitration starts from pointer 0
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    // 3 Contention with clients 0,1,3
    set_x(0, 8'd8);
    set_x(1, 8'd64);
    set_x(2, 8'd100);
    set_x(3, 8'd216);
    snap = done_cnt[2];
    req  = 4'b1011;
    push_exp(4'b0001, 8'd2, 1'b0);
    push_exp(4'b0010, 8'd4, 1'b0);
    push_exp(4'b1000, 8'd6, 1'b0);
    push_exp(4'b0001, 8'd2, 1'b0);
    for (int j = 0; j < 4; j++) wait_done("t3", 40, cyc);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("t3_no_client2", 64'(done_cnt[2] - snap), 64'd0);

    // 4 Requester drops mid-job
    set_x(1, 8'd125);
    req = 4'b0010;
    @(negedge clk);
    check("t4_gnt", 64'(gnt), 64'h2);
    cyc = 0;
    while (cr_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_in_wait", 64'({busy, cr_start}), 64'b10);
    req      = 4'b0000;
    acc_done = '0;
    acc_y    = '0;
    acc_err  = 1'b0;
    cyc      = 0;
    while (busy && cyc < 30) begin
      @(negedge clk);
      cyc++;
      acc_done = acc_done | done;
      acc_y    = acc_y | y;
      acc_err  = acc_err | err;
    end
    check("t4_finished", 64'(busy), 64'd0);
    check("t4_no_done",  64'(acc_done), 64'd0);
    check("t4_no_y",     64'(acc_y), 64'd0);
    check("t4_no_err",   64'(acc_err), 64'd0);
    set_x(2, 8'd1);
    req = 4'b0100;
    push_exp(4'b0100, 8'd1, 1'b0);
    wait_done("t4_next", 40, cyc);
    req = 4'b0000;
    @(negedge clk);

    // 5 Watchdog abort with the unit's busy tied low
    @(negedge clk);
    tie_busy = 1'b1;
    set_x(0, 8'd27);
    req = 4'b0001;
    push_exp(4'b0001, 8'hFF, 1'b1);
    @(negedge clk);
    check("t5_gnt", 64'(gnt), 64'h1);
    wait_done("t5", TO + 20, cyc);
    check("t5_latency", 64'(cyc), 64'(TO));
    check("t5_start_off", 64'(cr_start), 64'd0);
    req      = 4'b0000;
    tie_busy = 1'b0;
    @(negedge clk);
    check("t5_err_pulse", 64'(err), 64'd0);
    for (int j = 0; j < 6; j++) @(negedge clk);

    // 6 Reset in the middle of a job
    set_x(0, 8'd27);
    req = 4'b0001;
    @(negedge clk);
    cyc = 0;
    while (cr_start && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_in_wait", 64'({busy, cr_start}), 64'b10);
    snap = done_cnt[0];
    #5;
    rst_i = 1'b0;
    #1;
    check("t6_reset_outputs", 64'({gnt, done, y, err, busy, cr_start, cr_x}), 64'd0);
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check("t6_no_done", 64'(done_cnt[0] - snap), 64'd0);
    set_x(0, 8'd64);
    req = 4'b0001;
    push_exp(4'b0001, 8'd4, 1'b0);
    wait_done("t6_fresh", 40, cyc);
    req = 4'b0000;
    @(negedge clk);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
